// File: rtl/fifo_word_reader_if.sv
// Byte-FIFO read port and word output stream bundled for fifo_word_reader.
// master = the word reader itself, slave = the FIFO/sink environment around it.
interface fifo_word_reader_if #(
   parameter int BYTES = 4,
   parameter int CNTW  = 16
);
   logic                     r_ready;
   logic                     r_valid;
   logic [7:0]               r_data;
   logic                     o_valid;
   logic                     o_ready;
   logic [8*BYTES-1:0]       o_data;
   logic [$clog2(BYTES):0]   o_nbytes;
   logic                     o_partial;
   logic [CNTW-1:0]          word_cnt;

   modport master (
      input  r_ready, r_data, o_ready,
      output r_valid, o_valid, o_data, o_nbytes, o_partial, word_cnt
   );

   modport slave (
      output r_ready, r_data, o_ready,
      input  r_valid, o_valid, o_data, o_nbytes, o_partial, word_cnt
   );
endinterface

// File: rtl/fifo_word_reader.sv
// Pops bytes from a byte FIFO and packs BYTES of them little-endian into one word,
// presented on a valid/ready stream; flush emits a partially filled word.
module fifo_word_reader #(
   parameter int BYTES = 4,
   parameter int CNTW  = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                flush,
   fifo_word_reader_if.master  bus
);
   localparam int CW = $clog2(BYTES);
   localparam int NW = CW + 1;
   localparam logic [CW-1:0] LAST = CW'(BYTES - 1);
   localparam logic [NW-1:0] FULL = NW'(BYTES);

   typedef enum logic {
      FILL,
      OUT
   } state_t;

   state_t               state_q;
   logic [CW-1:0]        cnt_q;
   logic [8*BYTES-1:0]   data_q;
   logic [NW-1:0]        nbytes_q;
   logic                 partial_q;
   logic                 valid_q;
   logic [CNTW-1:0]      wordCnt_q;
   logic [CNTW-1:0]      wordCnt_d;
   logic                 popFire;

   // The pop request never looks at r_ready, so the FIFO sees no combinational loop.
   assign bus.r_valid = (state_q == FILL) & en & ~flush & ~rst;
   assign popFire     = bus.r_valid & bus.r_ready;
   assign wordCnt_d   = wordCnt_q + CNTW'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= FILL;
         cnt_q     <= '0;
         data_q    <= '0;
         nbytes_q  <= '0;
         partial_q <= 1'b0;
         valid_q   <= 1'b0;
         wordCnt_q <= '0;
      end else begin
         case (state_q)
            FILL: begin
               if (en && flush) begin
                  if (cnt_q != '0) begin
                     state_q   <= OUT;
                     valid_q   <= 1'b1;
                     nbytes_q  <= NW'(cnt_q);
                     partial_q <= 1'b1;
                     cnt_q     <= '0;
                  end
               end else if (popFire) begin
                  data_q[8*cnt_q +: 8] <= bus.r_data;
                  if (cnt_q == LAST) begin
                     state_q   <= OUT;
                     valid_q   <= 1'b1;
                     nbytes_q  <= FULL;
                     partial_q <= 1'b0;
                     cnt_q     <= '0;
                  end else begin
                     cnt_q <= cnt_q + CW'(1);
                  end
               end
            end
            OUT: begin
               // Lanes are zeroed on acceptance so a later flushed word reads 0 above o_nbytes.
               if (bus.o_ready) begin
                  state_q   <= FILL;
                  valid_q   <= 1'b0;
                  data_q    <= '0;
                  wordCnt_q <= wordCnt_d;
               end
            end
            default: state_q <= FILL;
         endcase
      end
   end

   assign bus.o_valid   = valid_q;
   assign bus.o_data    = data_q;
   assign bus.o_nbytes  = nbytes_q;
   assign bus.o_partial = partial_q;
   assign bus.word_cnt  = wordCnt_q;
endmodule

// File: tb/tb_fifo_word_reader.sv
// Directed, table-driven bench for fifo_word_reader (BYTES=4, CNTW=16),
// plus hand-written reset and gapped-feed sequences.
module tb_fifo_word_reader;
   logic clock;
   logic rst;
   logic en;
   logic flush;
   int   testsRun;
   int   testsFailed;

   fifo_word_reader_if #(.BYTES(4), .CNTW(16)) bus ();

   fifo_word_reader #(.BYTES(4), .CNTW(16)) dut (
      .clk   (clock),
      .rst   (rst),
      .en    (en),
      .flush (flush),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic        rst;
      logic        en;
      logic        flush;
      logic        rReady;
      logic [7:0]  rData;
      logic        oReady;
      logic        eRValid;
      logic        eOValid;
      logic [31:0] eData;
      logic [2:0]  eNb;
      logic        ePart;
      logic [15:0] eWc;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input int r, input int e, input int f, input int rr,
                               input int d, input int orr, input int erv, input int eov,
                               input logic [31:0] ed, input int enb, input int ep, input int ewc);
      vec_t v;
      v.rst     = (r != 0);
      v.en      = (e != 0);
      v.flush   = (f != 0);
      v.rReady  = (rr != 0);
      v.rData   = 8'(d);
      v.oReady  = (orr != 0);
      v.eRValid = (erv != 0);
      v.eOValid = (eov != 0);
      v.eData   = ed;
      v.eNb     = 3'(enb);
      v.ePart   = (ep != 0);
      v.eWc     = 16'(ewc);
      return v;
   endfunction

   task automatic checkOutput(input string name, input int idx, input logic [63:0] act,
                              input logic [63:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s (step %0d): got 0x%0h, expected 0x%0h", name, idx, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic r, input logic e, input logic f, input logic rr,
                                input logic [7:0] d, input logic orr);
      @(negedge clock);
      rst         = r;
      en          = e;
      flush       = f;
      bus.r_ready = rr;
      bus.r_data  = d;
      bus.o_ready = orr;
      #1;
   endtask

   task automatic doReset(input int tag);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 8'hEE, 1'b0);
      checkOutput("r_valid in reset", tag, 64'(bus.r_valid), 64'd0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 8'hEE, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      checkOutput("reset o_valid", tag, 64'(bus.o_valid), 64'd0);
      checkOutput("reset o_data", tag, 64'(bus.o_data), 64'd0);
      checkOutput("reset o_nbytes", tag, 64'(bus.o_nbytes), 64'd0);
      checkOutput("reset o_partial", tag, 64'(bus.o_partial), 64'd0);
      checkOutput("reset word_cnt", tag, 64'(bus.word_cnt), 64'd0);
   endtask

   initial begin
      logic [7:0] feed [4];
      int         idx;
      int         cyc;
      bit         seen;

      testsRun    = 0;
      testsFailed = 0;
      rst         = 1'b1;
      en          = 1'b0;
      flush       = 1'b0;
      bus.r_ready = 1'b0;
      bus.r_data  = 8'h00;
      bus.o_ready = 1'b0;

      // rst,en,flush,rReady,rData,oReady | rValid,oValid,oData,nbytes,partial,wordCnt
      vecs.push_back(mk(0,1,0,1,'h11,1, 1,0,0,0,0,0));
      vecs.push_back(mk(0,1,0,1,'h22,1, 1,0,0,0,0,0));
      vecs.push_back(mk(0,1,0,1,'h33,1, 1,0,0,0,0,0));
      vecs.push_back(mk(0,1,0,1,'h44,1, 1,0,0,0,0,0));
      vecs.push_back(mk(0,1,0,0,'h00,1, 0,1,'h44332211,4,0,0));
      vecs.push_back(mk(0,1,0,0,'h00,1, 1,0,0,0,0,1));
      vecs.push_back(mk(0,1,0,1,'h01,0, 1,0,0,0,0,1));
      vecs.push_back(mk(0,1,0,1,'h02,0, 1,0,0,0,0,1));
      vecs.push_back(mk(0,1,0,1,'h03,0, 1,0,0,0,0,1));
      vecs.push_back(mk(0,1,0,1,'h04,0, 1,0,0,0,0,1));
      for (int k = 0; k < 5; k++) vecs.push_back(mk(0,1,0,1,'h05,0, 0,1,'h04030201,4,0,1));
      vecs.push_back(mk(0,1,0,1,'h05,1, 0,1,'h04030201,4,0,1));
      vecs.push_back(mk(0,1,0,1,'h05,0, 1,0,0,0,0,2));
      vecs.push_back(mk(0,1,0,1,'h06,0, 1,0,0,0,0,2));
      vecs.push_back(mk(0,1,0,1,'h07,0, 1,0,0,0,0,2));
      vecs.push_back(mk(0,1,0,1,'h08,0, 1,0,0,0,0,2));
      vecs.push_back(mk(0,1,0,0,'h00,1, 0,1,'h08070605,4,0,2));
      vecs.push_back(mk(0,1,0,0,'h00,0, 1,0,0,0,0,3));
      vecs.push_back(mk(1,1,0,1,'hEE,0, 0,0,0,0,0,3));
      vecs.push_back(mk(0,1,0,1,'hAA,0, 1,0,0,0,0,0));
      vecs.push_back(mk(0,1,0,1,'hBB,0, 1,0,0,0,0,0));
      vecs.push_back(mk(0,1,1,1,'hCC,0, 0,0,0,0,0,0));
      vecs.push_back(mk(0,1,0,1,'hCC,1, 0,1,'h0000BBAA,2,1,0));
      vecs.push_back(mk(0,1,0,1,'hCC,0, 1,0,0,0,0,1));
      vecs.push_back(mk(0,1,0,1,'hDD,0, 1,0,0,0,0,1));
      vecs.push_back(mk(0,1,0,1,'hEE,0, 1,0,0,0,0,1));
      vecs.push_back(mk(0,1,0,1,'hFF,0, 1,0,0,0,0,1));
      vecs.push_back(mk(0,1,1,1,'h11,0, 0,1,'hFFEEDDCC,4,0,1));
      vecs.push_back(mk(0,1,0,0,'h00,1, 0,1,'hFFEEDDCC,4,0,1));
      vecs.push_back(mk(0,1,1,1,'h77,0, 0,0,0,0,0,2));
      vecs.push_back(mk(0,1,0,0,'h00,0, 1,0,0,0,0,2));
      vecs.push_back(mk(0,1,0,1,'h10,0, 1,0,0,0,0,2));
      vecs.push_back(mk(0,1,0,0,'h00,0, 1,0,0,0,0,2));
      vecs.push_back(mk(0,1,0,0,'h00,0, 1,0,0,0,0,2));
      vecs.push_back(mk(0,1,0,1,'h20,0, 1,0,0,0,0,2));
      for (int k = 0; k < 3; k++) vecs.push_back(mk(0,0,0,1,'h99,0, 0,0,0,0,0,2));
      vecs.push_back(mk(0,1,0,1,'h30,0, 1,0,0,0,0,2));
      vecs.push_back(mk(0,1,0,0,'h00,0, 1,0,0,0,0,2));
      vecs.push_back(mk(0,1,0,1,'h40,0, 1,0,0,0,0,2));
      vecs.push_back(mk(0,0,0,1,'h99,0, 0,1,'h40302010,4,0,2));
      vecs.push_back(mk(0,0,0,1,'h99,1, 0,1,'h40302010,4,0,2));
      vecs.push_back(mk(0,0,0,0,'h00,0, 0,0,0,0,0,3));
      vecs.push_back(mk(0,1,0,1,'hA1,0, 1,0,0,0,0,3));
      vecs.push_back(mk(0,1,0,1,'hA2,0, 1,0,0,0,0,3));
      vecs.push_back(mk(0,1,0,1,'hA3,0, 1,0,0,0,0,3));
      vecs.push_back(mk(1,1,0,1,'hA4,0, 0,0,0,0,0,3));
      vecs.push_back(mk(0,1,0,1,'hB1,0, 1,0,0,0,0,0));
      vecs.push_back(mk(0,1,0,1,'hB2,0, 1,0,0,0,0,0));
      vecs.push_back(mk(0,1,0,1,'hB3,0, 1,0,0,0,0,0));
      vecs.push_back(mk(0,1,0,1,'hB4,0, 1,0,0,0,0,0));
      vecs.push_back(mk(0,1,0,1,'h55,0, 0,1,'hB4B3B2B1,4,0,0));
      vecs.push_back(mk(1,1,0,1,'h55,0, 0,1,'hB4B3B2B1,4,0,0));
      vecs.push_back(mk(0,1,0,1,'hC1,0, 1,0,0,0,0,0));
      vecs.push_back(mk(0,1,0,1,'hC2,0, 1,0,0,0,0,0));
      vecs.push_back(mk(0,1,0,1,'hC3,0, 1,0,0,0,0,0));
      vecs.push_back(mk(0,1,0,1,'hC4,0, 1,0,0,0,0,0));
      vecs.push_back(mk(0,1,0,0,'h00,1, 0,1,'hC4C3C2C1,4,0,0));
      vecs.push_back(mk(0,1,0,0,'h00,0, 1,0,0,0,0,1));

      doReset(0);

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].flush, vecs[i].rReady,
                       vecs[i].rData, vecs[i].oReady);
         checkOutput("r_valid", i, 64'(bus.r_valid), 64'(vecs[i].eRValid));
         checkOutput("o_valid", i, 64'(bus.o_valid), 64'(vecs[i].eOValid));
         checkOutput("word_cnt", i, 64'(bus.word_cnt), 64'(vecs[i].eWc));
         if (vecs[i].eOValid) begin
            checkOutput("o_data", i, 64'(bus.o_data), 64'(vecs[i].eData));
            checkOutput("o_nbytes", i, 64'(bus.o_nbytes), 64'(vecs[i].eNb));
            checkOutput("o_partial", i, 64'(bus.o_partial), 64'(vecs[i].ePart));
         end
      end

      // Gapped feed with a bounded wait for the word, then a held-off sink.
      doReset(1000);
      feed[0] = 8'h5A;
      feed[1] = 8'hC3;
      feed[2] = 8'h0F;
      feed[3] = 8'h96;
      idx  = 0;
      seen = 1'b0;
      for (cyc = 0; cyc < 30 && !seen; cyc++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, (cyc % 3) != 1, (idx < 4) ? feed[idx] : 8'hEE, 1'b0);
         if (bus.o_valid) seen = 1'b1;
         else if (bus.r_valid && bus.r_ready) idx++;
      end
      checkOutput("gapped word appeared", 2000, 64'(seen), 64'd1);
      checkOutput("gapped pop count", 2000, 64'(idx), 64'd4);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'hEE, 1'b0);
         checkOutput("held o_data", 2001 + k, 64'(bus.o_data), 64'h960FC35A);
         checkOutput("held r_valid", 2001 + k, 64'(bus.r_valid), 64'd0);
      end
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      checkOutput("gapped word_cnt", 2010, 64'(bus.word_cnt), 64'd1);
      checkOutput("gapped o_valid drop", 2010, 64'(bus.o_valid), 64'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end
endmodule

// File: doc/fifo_word_reader.md
Name: fifo_word_reader

Overview:
Consumer for the 8-bit FIFO read port. It pops bytes from the FIFO and packs BYTES of them into one little-endian word. The word is presented on a valid/ready output stream. A flush input emits a partially filled word, and a word counter supports debug and scoreboarding. It sits between the byte FIFO and any word-wide sink, such as a bus writer or checksum unit.

Parameters:
BYTES  4  bytes per output word (2..8); o_data width = 8*BYTES
CNTW   16  width of word counter

Ports:
clk  input  1  clock
rst  input  1  reset; one clock; reset is synchronous and active-high
en  input  1  enable; 0 = stop popping, hold state
flush  input  1  emit partial word (level, sampled each cycle)
r_ready  input  1  from FIFO: head byte available (FIFO not empty)
r_valid  output  1  to FIFO: pop request; pop occurs when r_ready & r_valid at posedge
r_data  input  8  FIFO head byte, valid while r_ready=1
o_valid  output  1  output word valid
o_ready  input  1  sink accepts word
o_data  output  8*BYTES  packed word, byte k at bits [8k+7:8k]
o_nbytes  output  $clog2(BYTES)+1  number of valid bytes in o_data (1..BYTES)
o_partial  output  1  word was produced by flush (o_nbytes < BYTES)
word_cnt  output  CNTW  count of words accepted by sink

Behaviour:
- Reset (rst=1 at posedge): state=FILL, byte index cnt=0, o_data=0, o_valid=0, o_nbytes=0, o_partial=0, word_cnt=0. r_valid is 0 during the reset cycle. Reset mid-word discards the collected bytes; any FIFO pop in that cycle is suppressed.
- States: FILL (collecting bytes) and OUT (holding a word for the sink).
- r_valid = (state==FILL) & en & ~flush & ~rst. It is combinational from the registered state and inputs. It does not depend on r_ready.
- FILL, pop (r_ready & r_valid):
  - Store r_data into byte lane cnt.
  - If cnt==BYTES-1: next state=OUT, o_nbytes=BYTES, o_partial=0, cnt=0.
  - Otherwise cnt=cnt+1.
- FILL, flush=1 & en=1 & cnt>0: next state=OUT, o_nbytes=cnt, o_partial=1, cnt=0. Unfilled lanes read 0.
- FILL, flush=1 & cnt==0: no effect, and no pop occurs.
- FILL, r_ready=0: hold; no pop.
- OUT: o_valid=1 and r_valid=0. o_data, o_nbytes and o_partial stay stable until accepted.
- OUT, o_valid & o_ready at posedge: next state=FILL, o_data cleared to 0, word_cnt+1 (wraps modulo 2^CNTW).
- OUT, en=0: o_valid stays asserted; a handshake may still complete. en gates popping only.
- OUT, flush: ignored.
- Latency: the last byte popped at edge N gives o_valid=1 in the cycle after edge N. Acceptance at edge M allows the next pop at edge M+1.
- Peak throughput: one word per BYTES+1 cycles. No bubble is inserted between pops in FILL.
- Ready is never used to gate valid on the output side. o_valid must not drop without a handshake, except on rst.
- Simultaneous r_ready and flush: flush wins. No pop occurs, and the partial word is emitted.

Test Plan:
- Reset, then FIFO supplies 0x11,0x22,0x33,0x44 back-to-back, o_ready=1 -> r_valid high for 4 cycles; o_data=0x44332211, o_nbytes=4, o_partial=0, o_valid for 1 cycle; word_cnt=1.
- 8 bytes 0x01..0x08, o_ready held 0 for 5 cycles after first word -> first word 0x04030201 held stable; r_valid=0 while OUT; second word 0x08070605 follows after the handshake; word_cnt=2.
- Pop 0xAA,0xBB then pulse flush -> o_data=0x0000BBAA, o_nbytes=2, o_partial=1; next full word starts at lane 0.
- flush with cnt=0, and flush while r_ready=1 -> no pop, no output, r_valid=0 in the flush cycle.
- FIFO empty gaps (r_ready toggling 1,0,0,1,...) and en=0 for 3 cycles mid-word -> no pops while r_ready=0 or en=0; the word assembles correctly with no lost or duplicated bytes.
- Assert rst after 3 bytes popped and again while in OUT -> o_valid=0, cnt=0, word_cnt=0; next 4 bytes form a fresh word.
